sim_window_stats: RTL and testbench

Windowed statistics accumulator that sits directly downstream of the 12-bit Gaussian LFSR noise generator. It takes the 128-bit, 8-lane simulated sample word and, on command, accumulates sum, sum of squares, minimum and maximum over a fixed window of beats. Software uses the results to check the mean and RMS of the injected noise before that noise is handed to the trigger path.

---
 rtl/sim_window_stats.sv | 186 ++++++++++++++++++
 tb/tb_sim_window_stats.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_window_stats.sv
// rtl/sim_window_stats.sv - windowed sum, sum of squares, min and max over 8-lane sample beats
module sim_window_stats #(
  parameter int LOG2_BEATS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [127:0]               sim_data,
  output logic                       busy,
  output logic                       done,
  output logic                       result_valid,
  output logic [19+LOG2_BEATS-1:0]   sum,
  output logic [34+LOG2_BEATS-1:0]   sum_sq,
  output logic [15:0]                min_val,
  output logic [15:0]                max_val
);

  localparam int SUM_W = 19 + LOG2_BEATS;
  localparam int SQ_W  = 34 + LOG2_BEATS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Control state and registered status outputs
  state_t                  state_q, state_d;
  logic [LOG2_BEATS-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rv_q, rv_d;

  // S1: captured beat
  logic                    s1_valid_q, s1_valid_d;
  logic [127:0]            s1_data_q, s1_data_d;

  // S2: per-lane squares, lane sum, lane min/max
  logic                    s2_valid_q, s2_valid_d;
  logic [7:0][30:0]        s2_sq_q, s2_sq_d;
  logic [18:0]             s2_lsum_q, s2_lsum_d;
  logic [15:0]             s2_min_q, s2_min_d;
  logic [15:0]             s2_max_q, s2_max_d;

  // S3: window accumulators
  logic [SUM_W-1:0]        acc_sum_q, acc_sum_d;
  logic [SQ_W-1:0]         acc_sq_q, acc_sq_d;
  logic [15:0]             acc_min_q, acc_min_d;
  logic [15:0]             acc_max_q, acc_max_d;

  logic                    accept_start;
  logic                    capture;
  logic                    last_beat;
  logic                    drain_done;
  logic [15:0]             lane;
  logic [15:0]             mag;
  logic [33:0]             sq_tot;

  // Qualifying conditions shared by the FSM, counter and pipeline
  always_comb begin
    accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    capture      = (state_q == S_ACCUM) && in_valid;
    last_beat    = capture && (cnt_q == {LOG2_BEATS{1'b1}});
    drain_done   = (state_q == S_DRAIN) && !s1_valid_q && !s2_valid_q;
  end

  // Next state, beat counter and registered status outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)      state_d = S_ACCUM;
      S_ACCUM:        if (last_beat)  state_d = S_DRAIN;
      S_DRAIN:        if (drain_done) state_d = S_DONE;
      default:                        state_d = S_IDLE;
    endcase

    cnt_d = cnt_q;
    if (accept_start) begin
      cnt_d = '0;
    end else if (capture) begin
      cnt_d = cnt_q + LOG2_BEATS'(1);
    end

    busy_d = (state_d == S_ACCUM) || (state_d == S_DRAIN);
    done_d = drain_done;
    rv_d   = (state_d == S_DONE);
  end

  // S1 capture: sim_data only enters while a window is accumulating
  always_comb begin
    s1_valid_d = capture;
    s1_data_d  = capture ? sim_data : s1_data_q;
  end

  // S2 lane arithmetic; the square of |x| equals the signed square, including (-32768)^2 = 2^30
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sq_d    = '0;
    s2_lsum_d  = '0;
    s2_min_d   = 16'h7FFF;
    s2_max_d   = 16'h8000;
    lane       = '0;
    mag        = '0;
    for (int i = 0; i < 8; i++) begin
      lane = s1_data_q[16*i +: 16];
      mag  = lane[15] ? (16'd0 - lane) : lane;
      s2_sq_d[i] = {15'd0, mag} * {15'd0, mag};
      s2_lsum_d  = s2_lsum_d + {{3{lane[15]}}, lane};
      if ($signed(lane) < $signed(s2_min_d)) s2_min_d = lane;
      if ($signed(lane) > $signed(s2_max_d)) s2_max_d = lane;
    end
  end

  // S3 accumulation; a new window clears the results before any beat can reach this stage
  always_comb begin
    sq_tot = '0;
    for (int i = 0; i < 8; i++) begin
      sq_tot = sq_tot + {3'b000, s2_sq_q[i]};
    end

    acc_sum_d = acc_sum_q;
    acc_sq_d  = acc_sq_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    if (accept_start) begin
      acc_sum_d = '0;
      acc_sq_d  = '0;
      acc_min_d = 16'h7FFF;
      acc_max_d = 16'h8000;
    end else if (s2_valid_q) begin
      acc_sum_d = acc_sum_q + {{LOG2_BEATS{s2_lsum_q[18]}}, s2_lsum_q};
      acc_sq_d  = acc_sq_q + {{LOG2_BEATS{1'b0}}, sq_tot};
      if ($signed(s2_min_q) < $signed(acc_min_q)) acc_min_d = s2_min_q;
      if ($signed(s2_max_q) > $signed(acc_max_q)) acc_max_d = s2_max_q;
    end
  end

  // Control, valid bits and accumulators, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_sum_q  <= '0;
      acc_sq_q   <= '0;
      acc_min_q  <= 16'h7FFF;
      acc_max_q  <= 16'h8000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      acc_sum_q  <= acc_sum_d;
      acc_sq_q   <= acc_sq_d;
      acc_min_q  <= acc_min_d;
      acc_max_q  <= acc_max_d;
    end
  end

  // Pipeline data registers; their contents only matter when the matching valid bit is set
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    s2_sq_q   <= s2_sq_d;
    s2_lsum_q <= s2_lsum_d;
    s2_min_q  <= s2_min_d;
    s2_max_q  <= s2_max_d;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign sum          = acc_sum_q;
  assign sum_sq       = acc_sq_q;
  assign min_val      = acc_min_q;
  assign max_val      = acc_max_q;

endmodule

// File: tb/tb_sim_window_stats.sv
// tb/tb_sim_window_stats.sv - randomized self-checking bench for sim_window_stats
module tb_sim_window_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_v    [3];
  logic         in_valid_v [3];
  logic [127:0] data_v     [3];

  logic         busy0, done0, rv0, busy1, done1, rv1, busy2, done2, rv2;
  logic [19:0]  sum0;
  logic [34:0]  sq0;
  logic [20:0]  sum1;
  logic [35:0]  sq1;
  logic [28:0]  sum2;
  logic [43:0]  sq2;
  logic [15:0]  min0, max0, min1, max1, min2, max2;

  sim_window_stats #(.LOG2_BEATS(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]), .sim_data(data_v[0]),
    .busy(busy0), .done(done0), .result_valid(rv0), .sum(sum0), .sum_sq(sq0),
    .min_val(min0), .max_val(max0));

  sim_window_stats #(.LOG2_BEATS(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]), .sim_data(data_v[1]),
    .busy(busy1), .done(done1), .result_valid(rv1), .sum(sum1), .sum_sq(sq1),
    .min_val(min1), .max_val(max1));

  sim_window_stats #(.LOG2_BEATS(10)) u_l10 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid_v[2]), .sim_data(data_v[2]),
    .busy(busy2), .done(done2), .result_valid(rv2), .sum(sum2), .sum_sq(sq2),
    .min_val(min2), .max_val(max2));

  longint o_sum [3];
  longint o_sq  [3];
  longint o_min [3];
  longint o_max [3];
  logic   o_busy [3];
  logic   o_done [3];
  logic   o_rv   [3];

  assign o_sum[0] = longint'($signed(sum0));
  assign o_sum[1] = longint'($signed(sum1));
  assign o_sum[2] = longint'($signed(sum2));
  assign o_sq[0]  = longint'(sq0);
  assign o_sq[1]  = longint'(sq1);
  assign o_sq[2]  = longint'(sq2);
  assign o_min[0] = longint'($signed(min0));
  assign o_min[1] = longint'($signed(min1));
  assign o_min[2] = longint'($signed(min2));
  assign o_max[0] = longint'($signed(max0));
  assign o_max[1] = longint'($signed(max1));
  assign o_max[2] = longint'($signed(max2));
  assign o_busy[0] = busy0;
  assign o_busy[1] = busy1;
  assign o_busy[2] = busy2;
  assign o_done[0] = done0;
  assign o_done[1] = done1;
  assign o_done[2] = done2;
  assign o_rv[0]   = rv0;
  assign o_rv[1]   = rv1;
  assign o_rv[2]   = rv2;

  int           lg [3] = '{1, 2, 10};
  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] beat_q [$];
  logic [127:0] const_word;
  logic [31:0]  lfsr_s = 32'hACE1_1234;
  longint       exp_sum, exp_sq, exp_min, exp_max;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window statistics straight from the definition: every lane of every counted beat
  task automatic model();
    longint v;
    exp_sum = 0;
    exp_sq  = 0;
    exp_min = 32767;
    exp_max = -32768;
    foreach (beat_q[b]) begin
      for (int l = 0; l < 8; l++) begin
        v = longint'($signed(beat_q[b][16*l +: 16]));
        exp_sum += v;
        exp_sq  += v * v;
        if (v < exp_min) exp_min = v;
        if (v > exp_max) exp_max = v;
      end
    end
  endtask

  // Noise source: each lane is a centred sum of four 12-bit LFSR draws
  task automatic lfsr12(output int r);
    for (int k = 0; k < 12; k++) begin
      lfsr_s = lfsr_s[0] ? ((lfsr_s >> 1) ^ 32'h8020_0003) : (lfsr_s >> 1);
    end
    r = int'(lfsr_s[11:0]);
  endtask

  task automatic gen_word(input int mode, output logic [127:0] w);
    int a, b, c, d, s;
    w = '0;
    for (int l = 0; l < 8; l++) begin
      case (mode)
        0: w[16*l +: 16] = const_word[16*l +: 16];
        1: begin
          case ($urandom_range(0, 7))
            0:       w[16*l +: 16] = 16'h8000;
            1:       w[16*l +: 16] = 16'h7FFF;
            default: w[16*l +: 16] = 16'($urandom);
          endcase
        end
        default: begin
          lfsr12(a); lfsr12(b); lfsr12(c); lfsr12(d);
          s = a + b + c + d - 8190;
          w[16*l +: 16] = 16'(s);
        end
      endcase
    end
  endtask

  task automatic check_reset(input int idx, input string tag);
    check_eq({tag, "_busy"}, longint'(o_busy[idx]), 0);
    check_eq({tag, "_done"}, longint'(o_done[idx]), 0);
    check_eq({tag, "_rv"},   longint'(o_rv[idx]), 0);
    check_eq({tag, "_sum"},  o_sum[idx], 0);
    check_eq({tag, "_sq"},   o_sq[idx], 0);
    check_eq({tag, "_min"},  o_min[idx], 32767);
    check_eq({tag, "_max"},  o_max[idx], -32768);
  endtask

  // One window: start, feed beats per the valid mode, wait for done, compare with the model.
  // vmode 0: valid held high, 1: random gaps, 2: repeating 1,0,0,1
  task automatic run_window(input int idx, input int mode, input int vmode, input int exp_lat,
                            input int restart_at, input bit hold, input string tag);
    int nbeats, c, sent, mlast, done_at;
    bit got_done, busy_ok, v;
    logic [127:0] w;
    nbeats = 1 << lg[idx];
    beat_q.delete();
    start_v[idx]    = 1'b1;
    in_valid_v[idx] = 1'b0;
    data_v[idx]     = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start_v[idx] = 1'b0;
    check_eq({tag, "_start_busy"}, longint'(o_busy[idx]), 1);
    check_eq({tag, "_start_rv"},   longint'(o_rv[idx]), 0);
    check_eq({tag, "_start_sum"},  o_sum[idx], 0);
    check_eq({tag, "_start_min"},  o_min[idx], 32767);
    c = 0; sent = 0; mlast = -1; done_at = -1; got_done = 0; busy_ok = 1;
    while (!got_done && c < nbeats * 4 + 50) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 9) < 7);
        default: v = ((c % 4) == 0) || ((c % 4) == 3);
      endcase
      gen_word(mode, w);
      data_v[idx]     = w;
      in_valid_v[idx] = v;
      start_v[idx]    = (c == restart_at);
      if (v && sent < nbeats) beat_q.push_back(w);
      tick();
      c++;
      if (v && sent < nbeats) begin
        sent++;
        if (sent == nbeats) mlast = c;
      end
      if (o_done[idx]) begin
        got_done = 1;
        done_at  = c;
      end else if (!o_busy[idx]) begin
        busy_ok = 0;
      end
    end
    start_v[idx]    = 1'b0;
    in_valid_v[idx] = 1'b0;
    check_eq({tag, "_done_seen"}, longint'(got_done), 1);
    check_eq({tag, "_busy_window"}, longint'(busy_ok), 1);
    check_eq({tag, "_done_lat"}, done_at, mlast + 3);
    if (exp_lat > 0) check_eq({tag, "_start_to_done"}, done_at, exp_lat);
    check_eq({tag, "_busy_at_done"}, longint'(o_busy[idx]), 0);
    model();
    check_eq({tag, "_rv"},  longint'(o_rv[idx]), 1);
    check_eq({tag, "_sum"}, o_sum[idx], exp_sum);
    check_eq({tag, "_sq"},  o_sq[idx], exp_sq);
    check_eq({tag, "_min"}, o_min[idx], exp_min);
    check_eq({tag, "_max"}, o_max[idx], exp_max);
    if (hold) begin
      in_valid_v[idx] = 1'b1;
      tick();
      in_valid_v[idx] = 1'b0;
      check_eq({tag, "_done_pulse"}, longint'(o_done[idx]), 0);
      check_eq({tag, "_hold_rv"},  longint'(o_rv[idx]), 1);
      check_eq({tag, "_hold_sum"}, o_sum[idx], exp_sum);
      check_eq({tag, "_hold_sq"},  o_sq[idx], exp_sq);
    end
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i]    = 1'b0;
      in_valid_v[i] = 1'b0;
      data_v[i]     = '0;
    end
    const_word = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) check_reset(i, $sformatf("reset%0d", i));
    rst = 1'b0;
    tick();

    const_word = {8{16'h0010}};
    run_window(1, 0, 0, 7, -1, 1, "const");
    check_eq("const_sum_abs", o_sum[1], 512);
    check_eq("const_sq_abs",  o_sq[1], 8192);
    check_eq("const_min_abs", o_min[1], 16);
    check_eq("const_max_abs", o_max[1], 16);

    run_window(1, 0, 0, 7, -1, 0, "const_b2b_src");
    const_word = {8{16'h8000}};
    run_window(1, 0, 0, 7, -1, 1, "extreme");
    check_eq("extreme_sum_abs", o_sum[1], -(longint'(1) << 20));
    check_eq("extreme_sq_abs",  o_sq[1], longint'(1) << 35);
    check_eq("extreme_min_abs", o_min[1], -32768);
    check_eq("extreme_max_abs", o_max[1], -32768);

    const_word = {16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'hFFFF, 16'hFFFE, 16'hFFFD};
    run_window(0, 0, 2, 7, -1, 1, "mixed");
    check_eq("mixed_sum_abs", o_sum[0], 8);
    check_eq("mixed_sq_abs",  o_sq[0], 88);
    check_eq("mixed_min_abs", o_min[0], -3);
    check_eq("mixed_max_abs", o_max[0], 4);

    const_word = {8{16'h0010}};
    run_window(1, 0, 0, 7, 2, 1, "restart_busy");
    check_eq("restart_sum_abs", o_sum[1], 512);

    for (int n = 0; n < 6; n++) begin
      run_window(1, 1, 1, 0, (n % 2 == 0) ? int'($urandom_range(1, 3)) : -1, n % 3 != 0,
                 $sformatf("rand4_%0d", n));
      run_window(0, 1, 1, 0, -1, n % 2 == 0, $sformatf("rand2_%0d", n));
    end

    run_window(2, 2, 0, 1027, -1, 1, "live");

    start_v[2]    = 1'b1;
    tick();
    start_v[2]    = 1'b0;
    in_valid_v[2] = 1'b1;
    for (int i = 0; i < 512; i++) begin
      data_v[2] = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    tick();
    check_reset(2, "midrst");
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 600; i++) begin
      data_v[2] = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (o_done[2] || o_busy[2]) saw_done = 1;
    end
    in_valid_v[2] = 1'b0;
    check_eq("midrst_quiet", longint'(saw_done), 0);
    run_window(2, 2, 1, 0, -1, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
